// File: rtl/aximwr2wbsp.sv
// AXI4 write (AW/W/B) to pipelined Wishbone write bridge, one burst at a time.
// Latency: AW accept -> wready next cycle; W accept -> stb next cycle; last ack -> bvalid next cycle.
// Backpressure: wready drops while stb is stalled or the un-acked WB request window is full.
module aximwr2wbsp #(
    parameter int C_AXI_ID_WIDTH   = 6,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int LGFIFO           = 4
) (
    input  logic                          i_axi_clk,
    input  logic                          i_axi_reset,
    output logic                          o_axi_awready,
    input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
    input  logic [7:0]                    i_axi_awlen,
    input  logic [2:0]                    i_axi_awsize,
    input  logic [1:0]                    i_axi_awburst,
    input  logic                          i_axi_awlock,
    input  logic [3:0]                    i_axi_awcache,
    input  logic [2:0]                    i_axi_awprot,
    input  logic [3:0]                    i_axi_awqos,
    input  logic                          i_axi_awvalid,
    output logic                          o_axi_wready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
    input  logic                          i_axi_wlast,
    input  logic                          i_axi_wvalid,
    output logic [C_AXI_ID_WIDTH-1:0]     o_axi_bid,
    output logic [1:0]                    o_axi_bresp,
    output logic                          o_axi_bvalid,
    input  logic                          i_axi_bready,
    output logic                          o_wb_cyc,
    output logic                          o_wb_stb,
    output logic                          o_wb_we,
    output logic [C_AXI_ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [C_AXI_DATA_WIDTH-1:0]   o_wb_data,
    output logic [C_AXI_DATA_WIDTH/8-1:0] o_wb_sel,
    input  logic                          i_wb_ack,
    input  logic                          i_wb_stall,
    input  logic                          i_wb_err
);
    localparam int IDW = C_AXI_ID_WIDTH;
    localparam int DW  = C_AXI_DATA_WIDTH;
    localparam int AW  = C_AXI_ADDR_WIDTH;
    localparam int SW  = C_AXI_DATA_WIDTH / 8;
    // One spare bit: a stalled strobe can still issue after the window check passed.
    localparam int CW  = LGFIFO + 2;
    localparam logic [CW-1:0] MAX_OUT = CW'(2 ** LGFIFO);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FLUSH, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      beats_q, beats_d;
    logic            incr_q, incr_d;
    logic            err_q, err_d;
    logic            dead_q, dead_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic [AW-1:0]   wb_addr_q, wb_addr_d;
    logic [DW-1:0]   wb_data_q, wb_data_d;
    logic [SW-1:0]   wb_sel_q, wb_sel_d;
    logic [CW-1:0]   out_q, out_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [IDW-1:0]  bid_q, bid_d;
    logic            issue, ack_in, wready;

    logic unused_ok;
    assign unused_ok = ^{i_axi_awsize, i_axi_awburst[1], i_axi_awlock,
                         i_axi_awcache, i_axi_awprot, i_axi_awqos};

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        incr_d    = incr_q;
        err_d     = err_q;
        dead_d    = dead_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_sel_d  = wb_sel_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        wready    = 1'b0;

        issue  = stb_q && !i_wb_stall;
        ack_in = i_wb_ack && cyc_q;
        out_d  = out_q + CW'(issue) - CW'(ack_in);
        if (issue)
            stb_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_axi_awvalid) begin
                    id_d    = i_axi_awid;
                    addr_d  = i_axi_awaddr;
                    beats_d = i_axi_awlen;
                    incr_d  = i_axi_awburst[0];
                    dead_d  = 1'b0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // After a bus error the remaining beats are drained without touching the bus.
                wready = dead_q || ((!stb_q || !i_wb_stall) && (out_q < MAX_OUT));
                if (wready && i_axi_wvalid) begin
                    if (!dead_q) begin
                        cyc_d     = 1'b1;
                        stb_d     = 1'b1;
                        wb_addr_d = addr_q;
                        wb_data_d = i_axi_wdata;
                        wb_sel_d  = i_axi_wstrb;
                    end
                    addr_d = incr_q ? addr_q + AW'(1) : addr_q;
                    if (i_axi_wlast != (beats_q == 8'd0))
                        err_d = 1'b1;
                    if (beats_q == 8'd0)
                        state_d = S_FLUSH;
                    else
                        beats_d = beats_q - 8'd1;
                end
            end
            S_RESP: begin
                if (i_axi_bready) begin
                    bvalid_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: ;
        endcase

        if (i_wb_err && cyc_q) begin
            cyc_d  = 1'b0;
            stb_d  = 1'b0;
            out_d  = '0;
            err_d  = 1'b1;
            dead_d = 1'b1;
        end

        if (state_q == S_FLUSH && !stb_d && out_d == '0) begin
            cyc_d    = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = err_d ? 2'b10 : 2'b00;
            state_d  = S_RESP;
        end
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_reset) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            beats_q   <= '0;
            incr_q    <= 1'b0;
            err_q     <= 1'b0;
            dead_q    <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_sel_q  <= '0;
            out_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            beats_q   <= beats_d;
            incr_q    <= incr_d;
            err_q     <= err_d;
            dead_q    <= dead_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_sel_q  <= wb_sel_d;
            out_q     <= out_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
        end
    end

    assign o_axi_awready = (state_q == S_IDLE);
    assign o_axi_wready  = wready;
    assign o_axi_bid     = bid_q;
    assign o_axi_bresp   = bresp_q;
    assign o_axi_bvalid  = bvalid_q;
    assign o_wb_cyc      = cyc_q;
    assign o_wb_stb      = stb_q;
    assign o_wb_we       = 1'b1;
    assign o_wb_addr     = wb_addr_q;
    assign o_wb_data     = wb_data_q;
    assign o_wb_sel      = wb_sel_q;

endmodule

// File: tb/tb_aximwr2wbsp.sv
// Bench for aximwr2wbsp: directed bursts plus randomized bursts against a burst-level model,
// with a Wishbone slave that applies random stall/ack timing and optional error responses.
module tb_aximwr2wbsp;
    localparam int IDW = 6;
    localparam int DW  = 32;
    localparam int AW  = 28;
    localparam int SW  = DW / 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } wr_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           o_axi_awready;
    logic [IDW-1:0] i_axi_awid;
    logic [AW-1:0]  i_axi_awaddr;
    logic [7:0]     i_axi_awlen;
    logic [1:0]     i_axi_awburst;
    logic           i_axi_awvalid;
    logic           o_axi_wready;
    logic [DW-1:0]  i_axi_wdata;
    logic [SW-1:0]  i_axi_wstrb;
    logic           i_axi_wlast;
    logic           i_axi_wvalid;
    logic [IDW-1:0] o_axi_bid;
    logic [1:0]     o_axi_bresp;
    logic           o_axi_bvalid;
    logic           i_axi_bready;
    logic           o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]  o_wb_addr;
    logic [DW-1:0]  o_wb_data;
    logic [SW-1:0]  o_wb_sel;
    logic           i_wb_ack, i_wb_stall, i_wb_err;

    always #5 clk = ~clk;

    aximwr2wbsp #(.C_AXI_ID_WIDTH(IDW), .C_AXI_DATA_WIDTH(DW),
                  .C_AXI_ADDR_WIDTH(AW), .LGFIFO(4)) dut (
        .i_axi_clk(clk), .i_axi_reset(rst),
        .o_axi_awready(o_axi_awready), .i_axi_awid(i_axi_awid), .i_axi_awaddr(i_axi_awaddr),
        .i_axi_awlen(i_axi_awlen), .i_axi_awsize(3'd2), .i_axi_awburst(i_axi_awburst),
        .i_axi_awlock(1'b0), .i_axi_awcache(4'd0), .i_axi_awprot(3'd0), .i_axi_awqos(4'd0),
        .i_axi_awvalid(i_axi_awvalid),
        .o_axi_wready(o_axi_wready), .i_axi_wdata(i_axi_wdata), .i_axi_wstrb(i_axi_wstrb),
        .i_axi_wlast(i_axi_wlast), .i_axi_wvalid(i_axi_wvalid),
        .o_axi_bid(o_axi_bid), .o_axi_bresp(o_axi_bresp), .o_axi_bvalid(o_axi_bvalid),
        .i_axi_bready(i_axi_bready),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err)
    );

    int ncheck = 0, npass = 0, nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave knobs and observations
    int  stall_pct = 0, ack_pct = 100, err_at = -1, stall_req = -1, stall_left = 0;
    int  pend = 0, resp_idx = 0, cyc_n = 0;
    int  last_resp_cyc = -1, bv_rise_cyc = -1, late_stb = 0, stb_nocyc = 0, cyc_after_err = 0;
    bit  err_seen = 0, prev_err = 0;
    wr_t obs[$];

    always @(posedge clk) cyc_n++;

    initial begin
        i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0;
        forever begin
            @(negedge clk);
            i_wb_ack = 0;
            i_wb_err = 0;
            if (rst)
                pend = 0;
            else if (pend > 0 && $urandom_range(99) < ack_pct) begin
                if (resp_idx == err_at) begin
                    i_wb_err = 1;
                    pend = 0;
                end else begin
                    i_wb_ack = 1;
                    pend--;
                end
                resp_idx++;
            end
            if (o_wb_stb && stall_left > 0 && obs.size() == stall_req) begin
                i_wb_stall = 1;
                stall_left--;
            end else
                i_wb_stall = ($urandom_range(99) < stall_pct);
            #1;
            if (!rst) begin
                if (o_wb_stb && !o_wb_cyc) stb_nocyc++;
                if (prev_err && o_wb_cyc) cyc_after_err++;
                if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                    obs.push_back(wr_t'{o_wb_addr, o_wb_data, o_wb_sel});
                    if (err_seen) late_stb++;
                    if (!i_wb_err) pend++;
                end
                if (i_wb_ack || i_wb_err) last_resp_cyc = cyc_n;
                if (i_wb_err) err_seen = 1;
                if (o_axi_bvalid && bv_rise_cyc < 0) bv_rise_cyc = cyc_n;
            end
            prev_err = i_wb_err;
        end
    end

    task automatic aw_phase(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input int len, input bit incr);
        bit rdy;
        int t;
        i_axi_awvalid = 1;
        i_axi_awid    = id;
        i_axi_awaddr  = addr;
        i_axi_awlen   = 8'(len);
        i_axi_awburst = {1'b0, incr};
        t = 0;
        do begin
            #1 rdy = o_axi_awready;
            @(negedge clk);
            t++;
        end while (!rdy && t < 100);
        i_axi_awvalid = 0;
        check("aw_handshake", rdy, 1);
    endtask

    // One complete burst: model expectations, drive AW/W/B, compare.
    task automatic burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input bit incr, input logic [DW-1:0] d0, input logic [SW-1:0] s0,
                         input int bad_last, input int bhold, input int wgap_pct);
        wr_t ex[$];
        wr_t w;
        int  beat, t, n, mism;
        bit  acc, err_exp;
        obs.delete();
        err_seen = 0; late_stb = 0; stb_nocyc = 0; cyc_after_err = 0;
        resp_idx = 0; bv_rise_cyc = -1; last_resp_cyc = -1;
        for (int i = 0; i <= len; i++) begin
            w.a = incr ? AW'(addr + i) : addr;
            w.d = (i == 0) ? d0 : DW'($urandom);
            w.s = (i == 0) ? s0 : SW'($urandom);
            ex.push_back(w);
        end
        err_exp = (bad_last >= 0) || (err_at >= 0);

        @(negedge clk);
        aw_phase(id, addr, len, incr);

        beat = 0;
        t = 0;
        while (beat <= len && t < 3000) begin
            i_axi_wvalid = ($urandom_range(99) >= wgap_pct);
            i_axi_wdata  = ex[beat].d;
            i_axi_wstrb  = ex[beat].s;
            i_axi_wlast  = (beat == bad_last) ? (beat != len) : (beat == len);
            #1 acc = i_axi_wvalid && o_axi_wready;
            @(negedge clk);
            t++;
            if (acc) beat++;
        end
        i_axi_wvalid = 0;
        check("w_beats", beat, len + 1);

        i_axi_bready = 0;
        #1;
        t = 0;
        while (!o_axi_bvalid && t < 3000) begin
            @(negedge clk);
            #1 t++;
        end
        check("bvalid", o_axi_bvalid, 1);
        check("cyc_at_b", o_wb_cyc, 0);
        for (int k = 0; k < bhold; k++) begin
            @(negedge clk);
            #1;
        end
        if (bhold > 0) begin
            check("bvalid_hold", o_axi_bvalid, 1);
            check("awready_hold", o_axi_awready, 0);
        end
        check("bid", o_axi_bid, id);
        check("bresp", o_axi_bresp, err_exp ? 2'b10 : 2'b00);
        @(negedge clk);
        i_axi_bready = 1;
        @(negedge clk);
        i_axi_bready = 0;
        #1;
        check("bvalid_drop", o_axi_bvalid, 0);
        check("awready_back", o_axi_awready, 1);

        n = obs.size();
        mism = 0;
        for (int i = 0; i < n && i <= len; i++)
            if (obs[i] !== ex[i]) mism++;
        check("wb_writes", mism, 0);
        if (err_at >= 0) begin
            check("wb_count_err", (n >= err_at + 1) && (n <= len + 1), 1);
            check("late_stb", late_stb, 0);
            check("cyc_after_err", cyc_after_err, 0);
        end else begin
            check("wb_count", n, len + 1);
            check("b_latency", bv_rise_cyc, last_resp_cyc + 1);
        end
        check("stb_without_cyc", stb_nocyc, 0);
    endtask

    initial begin
        rst = 1;
        i_axi_awvalid = 0; i_axi_awid = 0; i_axi_awaddr = 0; i_axi_awlen = 0; i_axi_awburst = 0;
        i_axi_wvalid = 0; i_axi_wdata = 0; i_axi_wstrb = 0; i_axi_wlast = 0; i_axi_bready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_awready", o_axi_awready, 1);
        check("rst_wready", o_axi_wready, 0);
        check("rst_bvalid", o_axi_bvalid, 0);
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_bresp", o_axi_bresp, 0);
        check("rst_bid", o_axi_bid, 0);
        check("wb_we", o_wb_we, 1);

        // single beat
        burst(6'd5, 28'h100, 0, 1, 32'hDEADBEEF, 4'hF, -1, 0, 0);
        // INCR with two stall cycles on beat 1
        stall_req = 1; stall_left = 2;
        burst(6'd9, 28'h200, 3, 1, $urandom, 4'hF, -1, 0, 0);
        check("stall_consumed", stall_left, 0);
        stall_req = -1;
        // FIXED
        burst(6'd3, 28'h40, 2, 0, $urandom, 4'h3, -1, 0, 0);
        // bus error on beat 1
        err_at = 1;
        burst(6'd12, 28'h500, 3, 1, $urandom, 4'hF, -1, 0, 0);
        err_at = -1;
        // early wlast, response held off
        burst(6'd21, 28'h600, 2, 1, $urandom, 4'hC, 1, 5, 0);
        // address wrap
        burst(6'd33, 28'hFFFFFFE, 3, 1, $urandom, 4'hF, -1, 0, 0);

        // reset mid-burst
        ack_pct = 0;
        @(negedge clk);
        aw_phase(6'd7, 28'h300, 7, 1);
        i_axi_wvalid = 1; i_axi_wlast = 0; i_axi_wdata = 32'h12345678; i_axi_wstrb = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1;
        i_axi_wvalid = 0;
        #1 check("pre_rst_stb", o_wb_stb, 1);
        @(negedge clk);
        #1;
        check("mid_rst_cyc", o_wb_cyc, 0);
        check("mid_rst_stb", o_wb_stb, 0);
        check("mid_rst_bvalid", o_axi_bvalid, 0);
        check("mid_rst_awready", o_axi_awready, 1);
        @(negedge clk);
        rst = 0;
        ack_pct = 100;
        burst(6'd17, 28'h700, 0, 1, 32'hCAFEF00D, 4'h5, -1, 0, 0);

        // randomized bursts
        for (int r = 0; r < 24; r++) begin
            int len, bl;
            len       = $urandom_range(20);
            stall_pct = $urandom_range(50);
            ack_pct   = $urandom_range(100, 30);
            err_at    = ($urandom_range(4) == 0) ? int'($urandom_range(len)) : -1;
            bl        = ($urandom_range(5) == 0) ? int'($urandom_range(len)) : -1;
            burst(IDW'($urandom), ($urandom_range(3) == 0) ? AW'(28'hFFFFFF0 + $urandom_range(15))
                                                           : AW'($urandom),
                  len, $urandom_range(1), $urandom, SW'($urandom), bl,
                  $urandom_range(3), $urandom_range(50));
        end
        err_at = -1;

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
